// File: rtl/pdata_pkg.sv
// Shared opcodes and FSM states for the pdata_mac serial multiply-accumulate cell.
package pdata_pkg;

    localparam logic [2:0] OUT_DATA1 = 3'd0;
    localparam logic [2:0] OUT_DATA2 = 3'd1;
    localparam logic [2:0] OUT_RES   = 3'd2;
    localparam logic [2:0] LOAD      = 3'd3;
    localparam logic [2:0] LOAD_RES  = 3'd4;
    localparam logic [2:0] MUL       = 3'd5;
    localparam logic [2:0] MUL_ADD   = 3'd6;
    localparam logic [2:0] NO_OP     = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        WB   = 2'd2
    } state_e;

endpackage

// File: rtl/pdata_seq_mul.sv
// Radix-2 shift-add multiplier: SIZE iterations, the first on the start edge.
// Signed operands are multiplied as magnitudes and the product is negated on the way out.
module pdata_seq_mul
    import pdata_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              start,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    input  logic              signed_mode,
    output logic [2*SIZE-1:0] product,
    output logic              valid
);

    localparam int CW = $clog2(SIZE);

    logic [SIZE-1:0]   a_mag, b_mag;
    logic [2*SIZE-1:0] mcand_q, mcand_d;
    logic [2*SIZE-1:0] prod_q, prod_d;
    logic [SIZE-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              run_q, run_d;
    logic              valid_q, valid_d;

    always_comb begin
        a_mag    = (signed_mode && a[SIZE-1]) ? -a : a;
        b_mag    = (signed_mode && b[SIZE-1]) ? -b : b;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        run_d    = run_q;
        valid_d  = 1'b0;
        if (start) begin
            mcand_d  = {{SIZE{1'b0}}, a_mag} << 1;
            prod_d   = b_mag[0] ? {{SIZE{1'b0}}, a_mag} : '0;
            mplier_d = b_mag >> 1;
            neg_d    = signed_mode & (a[SIZE-1] ^ b[SIZE-1]);
            cnt_d    = CW'(SIZE - 1);
            run_d    = 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                run_d   = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            run_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            run_q    <= run_d;
            valid_q  <= valid_d;
        end
    end

    assign product = neg_q ? -prod_q : prod_q;
    assign valid   = valid_q;

endmodule

// File: rtl/pdata_mac.sv
// Serial-loaded multiply-accumulate cell with busy/done handshake and sticky overflow.
// Define PDATA_MAC_SAT_EN to saturate the accumulator on MUL_ADD overflow instead of wrapping.
module pdata_mac
    import pdata_pkg::*;
#(
    parameter int SIZE   = 32,
    parameter int ACC_W  = 4 * SIZE,
    parameter int SIGNED = 0
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx,
    input  logic [2:0] opcode,
    output logic       tx,
    output logic       tx_en,
    output logic       busy,
    output logic       done,
    output logic       ovf
);

    localparam logic SIGNED_MODE = (SIGNED != 0);

    state_e            state_q, state_d;
    logic [SIZE-1:0]   data_1_q, data_1_d;
    logic [SIZE-1:0]   data_2_q, data_2_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic              mac_q, mac_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              start;
    logic [2*SIZE-1:0] mul_product;
    logic              mul_valid;
    logic [ACC_W-1:0]  p_ext;
    logic [ACC_W:0]    sum;
    logic              add_ovf;
    logic [ACC_W-1:0]  mac_result;
    logic              tx_bit;

    assign start = (state_q == IDLE) && ((opcode == MUL) || (opcode == MUL_ADD));

    pdata_seq_mul #(.SIZE(SIZE)) u_mul (
        .clk         (clk),
        .nRst        (nRst),
        .start       (start),
        .a           (data_1_q),
        .b           (data_2_q),
        .signed_mode (SIGNED_MODE),
        .product     (mul_product),
        .valid       (mul_valid)
    );

    always_comb begin
        p_ext = {ACC_W{SIGNED_MODE & mul_product[2*SIZE-1]}};
        p_ext[2*SIZE-1:0] = mul_product;
        sum = {1'b0, acc_q} + {1'b0, p_ext};
        if (SIGNED_MODE) begin
            add_ovf = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
        end else begin
            add_ovf = sum[ACC_W];
        end
`ifdef PDATA_MAC_SAT_EN
        mac_result = sum[ACC_W-1:0];
        if (add_ovf) begin
            if (!SIGNED_MODE) begin
                mac_result = '1;
            end else if (acc_q[ACC_W-1]) begin
                mac_result = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                mac_result = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
`else
        mac_result = sum[ACC_W-1:0];
`endif
    end

    // Gated by nRst so the line is released while the cell is held in reset.
    always_comb begin
        tx_en  = 1'b0;
        tx_bit = 1'b0;
        if (nRst && state_q == IDLE) begin
            case (opcode)
                OUT_DATA1: begin tx_en = 1'b1; tx_bit = data_1_q[0]; end
                OUT_DATA2: begin tx_en = 1'b1; tx_bit = data_2_q[0]; end
                OUT_RES:   begin tx_en = 1'b1; tx_bit = acc_q[0];    end
                default:   ;
            endcase
        end
    end

    assign tx = tx_bit;

    always_comb begin
        state_d  = state_q;
        data_1_d = data_1_q;
        data_2_d = data_2_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        mac_d    = mac_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                case (opcode)
                    OUT_DATA1: data_1_d = {rx, data_1_q[SIZE-1:1]};
                    OUT_DATA2: data_2_d = {rx, data_2_q[SIZE-1:1]};
                    OUT_RES:   acc_d    = {1'b0, acc_q[ACC_W-1:1]};
                    LOAD: begin
                        data_1_d = {data_1_q[SIZE-2:0], rx};
                        data_2_d = {data_2_q[SIZE-2:0], data_1_q[SIZE-1]};
                    end
                    LOAD_RES: begin
                        acc_d = {acc_q[ACC_W-2:0], rx};
                        ovf_d = 1'b0;
                    end
                    MUL, MUL_ADD: begin
                        state_d = MULT;
                        mac_d   = (opcode == MUL_ADD);
                        busy_d  = 1'b1;
                    end
                    default: ;
                endcase
            end
            MULT: begin
                if (mul_valid) begin
                    state_d = WB;
                    done_d  = 1'b1;
                end
            end
            WB: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                acc_d   = mac_q ? mac_result : p_ext;
                if (mac_q && add_ovf) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= IDLE;
            data_1_q <= '0;
            data_2_q <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            mac_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_1_q <= data_1_d;
            data_2_q <= data_2_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            mac_q    <= mac_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_pdata_mac.sv
// Self-checking bench for pdata_mac: an unsigned and a signed instance (SIZE=8, ACC_W=32)
// share one stimulus stream; expected accumulator results travel through per-instance queues.
module tb_pdata_mac;
    import pdata_pkg::*;

    typedef struct {
        logic [31:0] acc;
        logic        ovf;
    } exp_t;

    logic       clk;
    logic       nRst;
    logic       rx;
    logic [2:0] opcode;
    logic       tx_u, tx_en_u, busy_u, done_u, ovf_u;
    logic       tx_s, tx_en_s, busy_s, done_s, ovf_s;

    int checks = 0;
    int errors = 0;

    exp_t q_u[$];
    exp_t q_s[$];

    logic [7:0]  m_d1, m_d2;
    logic [31:0] m_acc_u, m_acc_s;
    logic        m_ovf_u, m_ovf_s;

    pdata_mac #(.SIZE(8), .ACC_W(32), .SIGNED(0)) dut_u (
        .clk(clk), .nRst(nRst), .rx(rx), .opcode(opcode),
        .tx(tx_u), .tx_en(tx_en_u), .busy(busy_u), .done(done_u), .ovf(ovf_u)
    );

    pdata_mac #(.SIZE(8), .ACC_W(32), .SIGNED(1)) dut_s (
        .clk(clk), .nRst(nRst), .rx(rx), .opcode(opcode),
        .tx(tx_s), .tx_en(tx_en_s), .busy(busy_s), .done(done_s), .ovf(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic done in 64-bit integers, independent of the shift-add datapath.
    function automatic logic [32:0] model_u(logic [31:0] acc, logic [7:0] a, logic [7:0] b, bit add);
        logic [63:0] p, s;
        logic        ov;
        p  = {56'd0, a} * {56'd0, b};
        s  = add ? ({32'd0, acc} + p) : p;
        ov = add && s[32];
`ifdef PDATA_MAC_SAT_EN
        if (ov) s = 64'h0000_0000_FFFF_FFFF;
`endif
        return {ov, s[31:0]};
    endfunction

    function automatic logic [32:0] model_s(logic [31:0] acc, logic [7:0] a, logic [7:0] b, bit add);
        longint      sa, sp, ss;
        logic [63:0] raw;
        logic        ov;
        sa  = longint'($signed(acc));
        sp  = longint'($signed(a)) * longint'($signed(b));
        ss  = add ? (sa + sp) : sp;
        ov  = add && ((ss > 64'sd2147483647) || (ss < -64'sd2147483648));
        raw = ss;
`ifdef PDATA_MAC_SAT_EN
        if (ov) raw = (ss > 0) ? 64'h0000_0000_7FFF_FFFF : 64'hFFFF_FFFF_8000_0000;
`endif
        return {ov, raw[31:0]};
    endfunction

    task automatic cycle(input logic [2:0] op, input logic bit_in);
        opcode = op;
        rx     = bit_in;
        @(posedge clk);
        #1;
    endtask

    task automatic load_ops(input logic [7:0] d2, input logic [7:0] d1);
        for (int i = 7; i >= 0; i--) cycle(LOAD, d2[i]);
        for (int i = 7; i >= 0; i--) cycle(LOAD, d1[i]);
        opcode = NO_OP;
        m_d1 = d1;
        m_d2 = d2;
    endtask

    task automatic load_res(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) cycle(LOAD_RES, v[i]);
        opcode  = NO_OP;
        m_acc_u = v;
        m_acc_s = v;
        m_ovf_u = 1'b0;
        m_ovf_s = 1'b0;
    endtask

    task automatic run_mul(input bit add, input bit interfere, input string name);
        exp_t        eu, es, got;
        logic [32:0] ru, rs;
        int          busy_cnt, done_cnt;
        bit          finished;
        ru = model_u(m_acc_u, m_d1, m_d2, add);
        rs = model_s(m_acc_s, m_d1, m_d2, add);
        eu.acc = ru[31:0]; eu.ovf = m_ovf_u | ru[32];
        es.acc = rs[31:0]; es.ovf = m_ovf_s | rs[32];
        q_u.push_back(eu);
        q_s.push_back(es);
        opcode = add ? MUL_ADD : MUL;
        rx     = 1'b0;
        @(posedge clk);
        #1;
        busy_cnt = 0;
        done_cnt = 0;
        finished = 0;
        for (int k = 0; k < 40 && !finished; k++) begin
            if (interfere && k >= 1 && k <= 2) begin
                opcode = OUT_DATA1; rx = 1'b1;
            end else if (interfere && k >= 3 && k <= 4) begin
                opcode = LOAD; rx = 1'b1;
            end else begin
                opcode = NO_OP; rx = 1'b0;
            end
            @(negedge clk);
            if (interfere && k >= 1 && k <= 4) begin
                checks++;
                if (tx_en_u !== 1'b0 || tx_u !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s lockout_tx k=%0d: tx_en=%b tx=%b, required 0 0", name, k, tx_en_u, tx_u);
                end
            end
            if (busy_u === 1'b1) busy_cnt++;
            if (done_u === 1'b1) done_cnt++;
            if (busy_u !== 1'b1) finished = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        opcode = NO_OP;
        rx     = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("[TB] FAIL %s timeout: busy still %b after 40 cycles, required low", name, busy_u);
        end
        checks++;
        if (busy_cnt !== 9) begin
            errors++;
            $display("[TB] FAIL %s busy_cycles: got %0d, required 9", name, busy_cnt);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("[TB] FAIL %s done_pulses: got %0d, required 1", name, done_cnt);
        end
        got = q_u.pop_front();
        checks++;
        if (dut_u.acc_q !== got.acc || ovf_u !== got.ovf) begin
            errors++;
            $display("[TB] FAIL %s unsigned_acc: acc=%h ovf=%b, required acc=%h ovf=%b", name, dut_u.acc_q, ovf_u, got.acc, got.ovf);
        end
        got = q_s.pop_front();
        checks++;
        if (dut_s.acc_q !== got.acc || ovf_s !== got.ovf) begin
            errors++;
            $display("[TB] FAIL %s signed_acc: acc=%h ovf=%b, required acc=%h ovf=%b", name, dut_s.acc_q, ovf_s, got.acc, got.ovf);
        end
        m_acc_u = eu.acc; m_ovf_u = eu.ovf;
        m_acc_s = es.acc; m_ovf_s = es.ovf;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nRst   = 1'b0;
        opcode = OUT_DATA1;
        rx     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy_u, done_u, ovf_u, tx_en_u, tx_u} !== 5'b0 || dut_u.acc_q !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: busy/done/ovf/tx_en/tx=%b acc=%h, required 00000 00000000",
                     {busy_u, done_u, ovf_u, tx_en_u, tx_u}, dut_u.acc_q);
        end
        checks++;
        if (dut_u.data_1_q !== 8'd0 || dut_u.data_2_q !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: data_1=%h data_2=%h, required 00 00", dut_u.data_1_q, dut_u.data_2_q);
        end
        opcode = NO_OP;
        rx     = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        @(posedge clk);
        #1;
        m_d1 = '0; m_d2 = '0;
        m_acc_u = '0; m_acc_s = '0;
        m_ovf_u = 1'b0; m_ovf_s = 1'b0;
    endtask

    task automatic test_load_mul();
        load_ops(8'h05, 8'h03);
        checks++;
        if (dut_u.data_2_q !== 8'h05 || dut_u.data_1_q !== 8'h03) begin
            errors++;
            $display("[TB] FAIL load_operands: data_2=%h data_1=%h, required 05 03", dut_u.data_2_q, dut_u.data_1_q);
        end
        run_mul(1'b0, 1'b0, "mul_3x5");
    endtask

    task automatic test_mul_add_unload();
        logic [31:0] shifted;
        bit          en_ok;
        run_mul(1'b1, 1'b0, "mul_add_3x5");
        en_ok  = 1;
        opcode = OUT_RES;
        rx     = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            shifted[i] = tx_u;
            if (tx_en_u !== 1'b1) en_ok = 0;
            @(posedge clk);
            #1;
        end
        opcode = NO_OP;
        rx     = 1'b0;
        checks++;
        if (shifted !== 32'h0000_001E) begin
            errors++;
            $display("[TB] FAIL out_res_stream: got %h, required 0000001e", shifted);
        end
        checks++;
        if (!en_ok) begin
            errors++;
            $display("[TB] FAIL out_res_tx_en: dropped during unload, required 1 throughout");
        end
        checks++;
        if (dut_u.acc_q !== 32'd0) begin
            errors++;
            $display("[TB] FAIL out_res_final_acc: acc=%h, required 00000000", dut_u.acc_q);
        end
        m_acc_u = '0;
        m_acc_s = '0;
    endtask

    task automatic test_signed();
        load_ops(8'h05, 8'hFD);
        run_mul(1'b0, 1'b0, "signed_m3x5");
        load_ops(8'h80, 8'h80);
        run_mul(1'b0, 1'b0, "signed_min_sq");
    endtask

    task automatic test_overflow();
        load_res(32'hFFFF_FFF6);
        load_ops(8'h05, 8'h03);
        run_mul(1'b1, 1'b0, "ovf_unsigned");
        run_mul(1'b0, 1'b0, "ovf_sticky_mul");
        load_res(32'h7FFF_FFF6);
        run_mul(1'b1, 1'b0, "ovf_signed_pos");
        run_mul(1'b0, 1'b0, "ovf_signed_sticky");
        cycle(LOAD_RES, 1'b0);
        opcode  = NO_OP;
        m_acc_u = {m_acc_u[30:0], 1'b0};
        m_acc_s = {m_acc_s[30:0], 1'b0};
        m_ovf_u = 1'b0;
        m_ovf_s = 1'b0;
        checks++;
        if (ovf_s !== 1'b0 || ovf_u !== 1'b0 || dut_s.acc_q !== m_acc_s) begin
            errors++;
            $display("[TB] FAIL load_res_clears_ovf: ovf_s=%b ovf_u=%b acc=%h, required 0 0 %h", ovf_s, ovf_u, dut_s.acc_q, m_acc_s);
        end
    endtask

    task automatic test_busy_lockout();
        load_ops(8'h07, 8'h09);
        run_mul(1'b0, 1'b1, "lockout_7x9");
        checks++;
        if (dut_u.data_1_q !== 8'h09 || dut_u.data_2_q !== 8'h07) begin
            errors++;
            $display("[TB] FAIL lockout_operands: data_1=%h data_2=%h, required 09 07", dut_u.data_1_q, dut_u.data_2_q);
        end
    endtask

    task automatic test_reset_mid();
        int stray_done;
        load_ops(8'h0B, 8'h0D);
        opcode = MUL;
        @(posedge clk);
        #1;
        opcode = NO_OP;
        repeat (3) @(posedge clk);
        #1;
        opcode = OUT_DATA1;
        nRst   = 1'b0;
        #1;
        checks++;
        if ({busy_u, done_u, ovf_u, tx_en_u} !== 4'b0 || dut_u.acc_q !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: busy/done/ovf/tx_en=%b acc=%h, required 0000 00000000",
                     {busy_u, done_u, ovf_u, tx_en_u}, dut_u.acc_q);
        end
        opcode = NO_OP;
        m_d1 = '0; m_d2 = '0;
        m_acc_u = '0; m_acc_s = '0;
        m_ovf_u = 1'b0; m_ovf_s = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        stray_done = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done_u !== 1'b0 || busy_u !== 1'b0) stray_done++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (stray_done !== 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_no_done: %0d busy/done cycles after release, required 0", stray_done);
        end
        load_ops(8'h0B, 8'h0D);
        run_mul(1'b0, 1'b0, "after_reset_11x13");
    endtask

    initial begin
        nRst   = 1'b0;
        rx     = 1'b0;
        opcode = NO_OP;
        test_reset();
        test_load_mul();
        test_mul_add_unload();
        test_signed();
        test_overflow();
        test_busy_lockout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
